// File: rtl/countdown_pkg.sv
// Shared types and constants for the MM:SS BCD countdown engine.
package countdown_pkg;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    PAUSE,
    DONE
  } state_t;

  typedef struct packed {
    logic [3:0] min_t;
    logic [3:0] min_o;
    logic [3:0] sec_t;
    logic [3:0] sec_o;
  } bcd_time_t;

  localparam logic [3:0] SEC_T_MAX = 4'd5;
  localparam logic [3:0] MIN_T_MAX = 4'd5;
  localparam logic [3:0] DIGIT_MAX = 4'd9;

  function automatic logic is_legal_time(input bcd_time_t t);
    return (t.min_t <= MIN_T_MAX) && (t.min_o <= DIGIT_MAX) &&
           (t.sec_t <= SEC_T_MAX) && (t.sec_o <= DIGIT_MAX);
  endfunction

endpackage

// File: rtl/bcd_time_dec.sv
// Combinational one-second decrement of an MM:SS BCD time with borrow chain.
module bcd_time_dec
  import countdown_pkg::*;
(
  input  bcd_time_t time_in,
  output bcd_time_t time_out,
  output logic      is_zero
);

  always_comb begin
    time_out = time_in;
    if (time_in.sec_o != 4'd0) begin
      time_out.sec_o = time_in.sec_o - 4'd1;
    end else begin
      time_out.sec_o = DIGIT_MAX;
      if (time_in.sec_t != 4'd0) begin
        time_out.sec_t = time_in.sec_t - 4'd1;
      end else begin
        time_out.sec_t = SEC_T_MAX;
        if (time_in.min_o != 4'd0) begin
          time_out.min_o = time_in.min_o - 4'd1;
        end else begin
          time_out.min_o = DIGIT_MAX;
          time_out.min_t = time_in.min_t - 4'd1;
        end
      end
    end
  end

  // Flag describes the decremented result so the FSM can enter DONE on the same edge.
  assign is_zero = (time_out == '0);

endmodule

// File: rtl/countdown_bcd_core.sv
// MM:SS countdown FSM with 1 Hz prescaler; all display-side outputs registered.
module countdown_bcd_core
  import countdown_pkg::*;
#(
  parameter int unsigned CLK_HZ  = 50_000_000,
  parameter int unsigned TICK_HZ = 1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        load,
  input  logic [15:0] load_value,
  input  logic        start_pause,
  input  logic        clear,
  output logic [15:0] bcd_out,
  output logic [3:0]  dp_out,
  output logic        blank,
  output logic        done,
  output logic        load_err
);

  localparam int unsigned PRESCALE = CLK_HZ / TICK_HZ;
  localparam int unsigned PW       = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam logic [PW-1:0] PS_LAST = PW'(PRESCALE - 1);
  localparam logic [PW-1:0] PS_HALF = PW'(PRESCALE / 2);

  state_t        state_q, state_d;
  bcd_time_t     time_q, time_d;
  logic [PW-1:0] presc_q, presc_d, presc_inc;
  logic          load_err_d, dp2_q, dp2_d, blank_d, done_d;

  bcd_time_t load_time, dec_time;
  logic      dec_zero, load_ok, tick, time_zero;

  assign load_time = bcd_time_t'(load_value);
  assign load_ok   = is_legal_time(load_time);
  assign time_zero = (time_q == '0);
  assign tick      = (presc_q == PS_LAST);
  assign presc_inc = tick ? '0 : presc_q + 1'b1;

  bcd_time_dec u_dec (
    .time_in  (time_q),
    .time_out (dec_time),
    .is_zero  (dec_zero)
  );

  always_comb begin
    state_d    = state_q;
    time_d     = time_q;
    presc_d    = presc_q;
    load_err_d = 1'b0;
    unique case (state_q)
      IDLE: begin
        presc_d = '0;
        if (clear) begin
          time_d = '0;
        end else if (load) begin
          if (load_ok) time_d = load_time;
          else         load_err_d = 1'b1;
        end else if (start_pause && !time_zero) begin
          state_d = RUN;
        end
      end
      RUN: begin
        // load is a no-op while running and does not mask start_pause or the tick.
        if (clear) begin
          state_d = IDLE;
          time_d  = '0;
          presc_d = '0;
        end else if (start_pause) begin
          state_d = PAUSE;
        end else begin
          presc_d = presc_inc;
          if (tick) begin
            time_d = dec_time;
            if (dec_zero) state_d = DONE;
          end
        end
      end
      PAUSE: begin
        if (clear) begin
          state_d = IDLE;
          time_d  = '0;
          presc_d = '0;
        end else if (load) begin
          if (load_ok) begin
            state_d = IDLE;
            time_d  = load_time;
            presc_d = '0;
          end else begin
            load_err_d = 1'b1;
          end
        end else if (start_pause) begin
          state_d = RUN;
        end
      end
      DONE: begin
        presc_d = presc_inc;
        if (clear || (!load && start_pause)) begin
          state_d = IDLE;
          time_d  = '0;
          presc_d = '0;
        end else if (load) begin
          if (load_ok) begin
            state_d = IDLE;
            time_d  = load_time;
            presc_d = '0;
          end else begin
            load_err_d = 1'b1;
          end
        end
      end
    endcase
  end

  always_comb begin
    dp2_d   = 1'b0;
    blank_d = 1'b0;
    done_d  = 1'b0;
    unique case (state_d)
      IDLE, PAUSE: dp2_d = 1'b1;
      RUN:         dp2_d = (presc_d < PS_HALF);
      DONE: begin
        done_d  = 1'b1;
        blank_d = (presc_d >= PS_HALF);
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      time_q   <= '0;
      presc_q  <= '0;
      dp2_q    <= 1'b0;
      blank    <= 1'b0;
      done     <= 1'b0;
      load_err <= 1'b0;
    end else begin
      state_q  <= state_d;
      time_q   <= time_d;
      presc_q  <= presc_d;
      dp2_q    <= dp2_d;
      blank    <= blank_d;
      done     <= done_d;
      load_err <= load_err_d;
    end
  end

  assign bcd_out = time_q;
  assign dp_out  = {1'b0, dp2_q, 2'b00};

endmodule
